pueo_event_addr_freelist: RTL and testbench
===========================================

Name: pueo_event_addr_freelist

Overview:
- Supplies free event-buffer addresses to the TURFIO event request generator's s_done input.
- Each address handed out names one event slot in DDR4.
- Readout logic returns addresses on s_free once the slot is drained; returned addresses are re-issued in FIFO order.
- Lives in the memclk (DDR4 UI clock) domain, replacing the free-running counter used in bring-up.

Parameters:
NUM_ADDR, 4096, number of event slots; power of 2, >= 4.
DATA_WIDTH, 16, width of address tdata; must satisfy 2^DATA_WIDTH >= NUM_ADDR.

Ports:
memclk  in  1  clock (DDR4 UI clock).
memresetn  in  1  synchronous active-low reset.
m_done_tdata  out  DATA_WIDTH  next free address.
m_done_tvalid  out  1  address available.
m_done_tready  in  1  consumer accepts.
s_free_tdata  in  DATA_WIDTH  returned address.
s_free_tvalid  in  1  returned address valid.
s_free_tready  out  1  0 during INIT, 1 in RUN.
init_done_o  out  1  INIT complete.
free_count_o  out  DATA_WIDTH+1  addresses currently held (RAM + output register).
overflow_err_o  out  1  sticky: free accepted while free_count_o == NUM_ADDR.
range_err_o  out  1  sticky: free value >= NUM_ADDR.

Behaviour:
- Reset (memresetn low at posedge):
  - State INIT; wr_ptr = rd_ptr = 0; RAM count = 0; output register empty.
  - All outputs 0: m_done_tvalid, m_done_tdata, s_free_tready, init_done_o, free_count_o, both error flags.
  - Reset mid-operation discards all contents and restarts INIT.
- INIT:
  - One RAM write per cycle: value k at address k, k = 0..NUM_ADDR-1. Takes exactly NUM_ADDR cycles after reset release.
  - free_count_o increments by 1 per write.
  - After the last write: state RUN, init_done_o = 1, wr_ptr wraps to 0.
- RUN (terminal until reset):
  - s_free_tready = 1 constantly.
- Storage:
  - Circular buffer of NUM_ADDR entries, simple dual-port RAM with 1-cycle registered read.
  - First-word-fall-through output register feeds m_done.
  - Pointers are log2(NUM_ADDR) bits and wrap naturally.
- Output prefetch:
  - When the output register is empty or being popped (tvalid & tready), and RAM count > 0, issue a RAM read.
  - Read data lands in the output register one cycle later.
  - After the RAM read is issued, rd_ptr increments and RAM count decrements.
- Timing:
  - m_done_tvalid rises 2 cycles after init_done_o rises, carrying address 0.
  - Back-to-back pops sustain 1 address/cycle while RAM count > 0.
  - A free accepted while completely empty appears on m_done 2 cycles later.
- m_done_tdata and m_done_tvalid are held stable while tvalid & !tready (AXI4-Stream rule).
- Accepting a free:
  - Valid free: value < NUM_ADDR and free_count_o < NUM_ADDR. Written at wr_ptr; wr_ptr and RAM count increment.
  - value >= NUM_ADDR: dropped, range_err_o set.
  - free_count_o == NUM_ADDR (double free): dropped, overflow_err_o set.
  - If both conditions hold in one cycle, both flags are set.
  - Error flags clear only on reset.
- Simultaneous pop and valid free in one cycle: free_count_o unchanged.
- Empty case:
  - free_count_o == 0 gives m_done_tvalid = 0.
  - No error is raised; upstream backpressure is the required behaviour.
- free_count_o:
  - Registered; reflects accepts and pops of the previous cycle.
  - Range is 0..NUM_ADDR.

Decomposition:
- pueo_event_pkg holds:
  - EVADDR_WIDTH = 16
  - NUM_EVENT_SLOTS = 4096
  - freelist state enum {INIT, RUN}
- One sub-module, pueo_addr_ram: simple dual-port RAM with synchronous write and 1-cycle registered read, parameterised depth/width, inferred as BRAM.
- Pointer/count/FSM logic and the FWFT register stay in the top.

Test Plan:
- Reset release with NUM_ADDR=16, m_done_tready=1:
  - init_done_o high at cycle 16.
  - m_done emits 0,1,...,15 on consecutive cycles from cycle 18.
  - free_count_o goes 16 -> 0; tvalid then low.
- Drain all 16, then free 5, 9, 2 on consecutive cycles:
  - m_done emits 5, 9, 2 in order, first 2 cycles after the free of 5.
  - free_count_o peaks at 3.
- Steady state with 8 held, one pop and one free (value 3) every cycle for 100 cycles:
  - free_count_o stays 8.
  - Popped sequence is the prior FIFO contents followed by 3s.
- Free value 20 with NUM_ADDR=16: dropped, range_err_o = 1, free_count_o unchanged.
- Free while free_count_o == 16: dropped, overflow_err_o = 1, and the next 16 pops still return 0..15.
- Hold m_done_tready=0 for 10 cycles after init: tdata stays 0 and tvalid stays 1.
- Assert memresetn low for 1 cycle mid-drain:
  - All outputs 0 the next cycle.
  - INIT reruns, then m_done restarts at address 0.

Source files
------------

// File: rtl/pueo_event_pkg.sv
// Shared constants and types for the PUEO event-buffer address free list.
package pueo_event_pkg;

  // Default width of an event-buffer address on the AXI4-Stream side.
  localparam int EVADDR_WIDTH    = 16;
  // Default number of event slots held in DDR4.
  localparam int NUM_EVENT_SLOTS = 4096;

  // Free-list controller phase: INIT seeds the RAM, RUN serves traffic.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } freelist_state_e;

endpackage : pueo_event_pkg

// File: rtl/pueo_addr_ram.sv
// Simple dual-port RAM: one synchronous write port, one read port with a
// single registered read stage. Written so synthesis maps it onto block RAM.
module pueo_addr_ram #(
  parameter int DEPTH  = 4096,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port.
  // NOTE: the array has no reset; a reset port would stop it mapping onto block RAM, and the controller never reads an entry it has not written.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; holds its last value when no read is issued.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : pueo_addr_ram

// File: rtl/pueo_event_addr_freelist.sv
// Free list of DDR4 event-slot addresses. After reset it seeds a circular
// buffer with 0..NUM_ADDR-1, then hands addresses out on m_done in FIFO order
// and takes drained slots back on s_free. Output is first-word-fall-through:
// RAM read register -> output register -> m_done.
module pueo_event_addr_freelist
  import pueo_event_pkg::*;
#(
  parameter int NUM_ADDR   = NUM_EVENT_SLOTS,
  parameter int DATA_WIDTH = EVADDR_WIDTH
) (
  input  logic                  memclk,
  input  logic                  memresetn,
  output logic [DATA_WIDTH-1:0] m_done_tdata,
  output logic                  m_done_tvalid,
  input  logic                  m_done_tready,
  input  logic [DATA_WIDTH-1:0] s_free_tdata,
  input  logic                  s_free_tvalid,
  output logic                  s_free_tready,
  output logic                  init_done_o,
  output logic [DATA_WIDTH:0]   free_count_o,
  output logic                  overflow_err_o,
  output logic                  range_err_o
);

  localparam int AW = $clog2(NUM_ADDR);
  localparam logic [DATA_WIDTH:0] NUM_ADDR_C = (DATA_WIDTH + 1)'(NUM_ADDR);
  localparam logic [AW-1:0]       LAST_ADDR  = AW'(NUM_ADDR - 1);

  freelist_state_e       state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           ram_cnt_q, ram_cnt_d;     // entries resident in RAM
  logic                  pend_q, pend_d;           // RAM read register holds an address
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH:0]   free_cnt_q, free_cnt_d;   // all addresses held by the list
  logic                  ovf_q, ovf_d;
  logic                  rng_q, rng_d;

  logic                  free_acc;
  logic                  free_big;
  logic                  free_full;
  logic                  free_ok;
  logic                  init_wr;
  logic                  ram_wr_en;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_rd_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  pop;
  logic                  out_load;

  pueo_addr_ram #(
    .DEPTH (NUM_ADDR),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk       (memclk),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (ram_wr_data),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  // Handshake decode, RAM port control and next-state computation.
  // NOTE: every signal gets a value on every path through this block so no latch is inferred.
  always_comb begin
    // Free-side acceptance: only in RUN, dropped on a bad value or a full list.
    free_acc    = (state_q == RUN) && s_free_tvalid;
    free_big    = ({1'b0, s_free_tdata} >= NUM_ADDR_C);
    free_full   = (free_cnt_q == NUM_ADDR_C);
    free_ok     = free_acc && !free_big && !free_full;

    // INIT writes k at address k; wr_ptr doubles as the seed counter.
    init_wr     = (state_q == INIT);
    ram_wr_en   = init_wr || free_ok;
    ram_wr_data = init_wr ? DATA_WIDTH'(wr_ptr_q) : s_free_tdata;

    // The read register moves into the output register when that is empty or
    // being popped; a new read may be issued whenever the read register will
    // be free at the next edge, which keeps pops at one per cycle.
    pop         = out_valid_q && m_done_tready;
    out_load    = pend_q && (!out_valid_q || pop);
    ram_rd_en   = (state_q == RUN) && (ram_cnt_q != '0) && (!pend_q || out_load);

    state_d     = (init_wr && (wr_ptr_q == LAST_ADDR)) ? RUN : state_q;
    wr_ptr_d    = ram_wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = ram_rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ram_cnt_d   = ram_cnt_q + (AW + 1)'(ram_wr_en) - (AW + 1)'(ram_rd_en);
    free_cnt_d  = free_cnt_q + (DATA_WIDTH + 1)'(ram_wr_en) - (DATA_WIDTH + 1)'(pop);
    pend_d      = ram_rd_en || (pend_q && !out_load);
    out_valid_d = out_load || (out_valid_q && !pop);
    out_data_d  = out_load ? ram_rd_data : out_data_q;
    ovf_d       = ovf_q || (free_acc && free_full);
    rng_d       = rng_q || (free_acc && free_big);
  end

  // State registers; synchronous reset discards contents and restarts INIT.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge memclk) begin
    if (!memresetn) begin
      state_q     <= INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      free_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      rng_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      free_cnt_q  <= free_cnt_d;
      ovf_q       <= ovf_d;
      rng_q       <= rng_d;
    end
  end

  assign m_done_tdata   = out_data_q;
  assign m_done_tvalid  = out_valid_q;
  assign s_free_tready  = (state_q == RUN);
  assign init_done_o    = (state_q == RUN);
  assign free_count_o   = free_cnt_q;
  assign overflow_err_o = ovf_q;
  assign range_err_o    = rng_q;

endmodule : pueo_event_addr_freelist

// File: tb/tb_pueo_event_addr_freelist.sv
// Self-checking bench for pueo_event_addr_freelist (NUM_ADDR = 16).
// The reference is a queue of held addresses, each tagged with the first
// cycle it may appear on m_done; every negedge the DUT outputs are compared
// against it. Directed phases add literal expectations on top.
module tb_pueo_event_addr_freelist;

  localparam int N  = 16;
  localparam int DW = 16;

  logic          memclk = 1'b0;
  logic          memresetn = 1'b0;
  logic [DW-1:0] m_done_tdata;
  logic          m_done_tvalid;
  logic          m_done_tready = 1'b0;
  logic [DW-1:0] s_free_tdata = '0;
  logic          s_free_tvalid = 1'b0;
  logic          s_free_tready;
  logic          init_done_o;
  logic [DW:0]   free_count_o;
  logic          overflow_err_o;
  logic          range_err_o;

  always #5 memclk = ~memclk;

  pueo_event_addr_freelist #(
    .NUM_ADDR   (N),
    .DATA_WIDTH (DW)
  ) dut (
    .memclk         (memclk),
    .memresetn      (memresetn),
    .m_done_tdata   (m_done_tdata),
    .m_done_tvalid  (m_done_tvalid),
    .m_done_tready  (m_done_tready),
    .s_free_tdata   (s_free_tdata),
    .s_free_tvalid  (s_free_tvalid),
    .s_free_tready  (s_free_tready),
    .init_done_o    (init_done_o),
    .free_count_o   (free_count_o),
    .overflow_err_o (overflow_err_o),
    .range_err_o    (range_err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int val;
    int ready;   // first cycle the address may be presented on m_done
  } ent_t;

  ent_t q[$];
  int   cyc    = 0;    // clock edges since reset release
  bit   run    = 0;
  int   init_k = 0;
  bit   m_ovf  = 0;
  bit   m_rng  = 0;
  bit   m_live = 0;    // model valid once the first reset edge has happened
  bit   m_rst  = 0;    // last edge was a reset edge

  function automatic bit exp_valid();
    return run && (q.size() > 0) && (q[0].ready <= cyc);
  endfunction

  always @(posedge memclk) begin
    if (!memresetn) begin
      q.delete();
      cyc = 0; run = 0; init_k = 0; m_ovf = 0; m_rng = 0;
      m_live = 1; m_rst = 1;
    end else if (m_live) begin
      bit v;
      bit pop;
      bit acc;
      int sz;
      v   = exp_valid();
      pop = v && m_done_tready;
      acc = run && s_free_tvalid;
      sz  = q.size();
      cyc++;
      m_rst = 0;
      if (pop) void'(q.pop_front());
      if (!run) begin
        // Seeding: address k held from edge k+1; none can leave before
        // RUN starts at cycle N, so the first appears at cycle N+2.
        q.push_back('{init_k, N + 2});
        init_k++;
        if (init_k == N) run = 1;
      end else if (acc) begin
        if (int'(s_free_tdata) >= N) m_rng = 1;
        if (sz == N) m_ovf = 1;
        if (int'(s_free_tdata) < N && sz < N) q.push_back('{int'(s_free_tdata), cyc + 2});
      end
    end
  end

  // Compare process: all outputs against the model on every cycle.
  always @(negedge memclk) begin
    if (m_live) begin
      bit v;
      v = exp_valid();
      check("tvalid", m_done_tvalid, v);
      if (v) check("tdata", m_done_tdata, q[0].val);
      if (m_rst) check("tdata_after_reset", m_done_tdata, 0);
      check("s_free_tready", s_free_tready, run);
      check("init_done", init_done_o, run);
      check("free_count", free_count_o, q.size());
      check("overflow_err", overflow_err_o, m_ovf);
      check("range_err", range_err_o, m_rng);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rn, input bit rdy, input bit fv, input int fd);
    memresetn     = rn;
    m_done_tready = rdy;
    s_free_tvalid = fv;
    s_free_tdata  = DW'(fd);
    @(negedge memclk);
  endtask

  initial begin
    // Reset, then release with consumer ready.
    repeat (3) drive(0, 1, 0, 0);
    repeat (16) drive(1, 1, 0, 0);
    check("lit_init_done_c16", init_done_o, 1);
    check("lit_count_c16", free_count_o, 16);
    check("lit_tvalid_c16", m_done_tvalid, 0);
    repeat (2) drive(1, 1, 0, 0);
    check("lit_tvalid_c18", m_done_tvalid, 1);
    for (int i = 0; i < 16; i++) begin
      check("lit_drain_seq", m_done_tdata, i);
      drive(1, 1, 0, 0);
    end
    check("lit_empty_tvalid", m_done_tvalid, 0);
    check("lit_empty_count", free_count_o, 0);

    // Free 5, 9, 2 on consecutive cycles while empty.
    drive(1, 1, 1, 5);
    drive(1, 1, 1, 9);
    drive(1, 1, 1, 2);
    check("lit_peak_count", free_count_o, 3);
    check("lit_first_free_valid", m_done_tvalid, 1);
    check("lit_first_free_data", m_done_tdata, 5);
    drive(1, 1, 0, 0);
    check("lit_second_free", m_done_tdata, 9);
    drive(1, 1, 0, 0);
    check("lit_third_free", m_done_tdata, 2);
    drive(1, 1, 0, 0);
    check("lit_empty_again", m_done_tvalid, 0);

    // Build up 8 held entries, then pop one and free a 3 every cycle.
    for (int k = 0; k < 8; k++) drive(1, 0, 1, k + 8);
    repeat (4) drive(1, 0, 0, 0);
    check("lit_held8", free_count_o, 8);
    for (int i = 0; i < 100; i++) begin
      check("lit_steady_seq", m_done_tdata, (i < 8) ? i + 8 : 3);
      drive(1, 1, 1, 3);
    end
    check("lit_steady_count", free_count_o, 8);
    repeat (12) drive(1, 1, 0, 0);

    // Out-of-range free.
    drive(1, 1, 1, 20);
    check("lit_range_err", range_err_o, 1);
    check("lit_range_count", free_count_o, 0);
    drive(1, 1, 0, 0);

    // Reset, stall after init, double free while full, then full drain.
    drive(0, 0, 0, 0);
    check("lit_range_cleared", range_err_o, 0);
    repeat (18) drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check("lit_stall_valid", m_done_tvalid, 1);
      check("lit_stall_data", m_done_tdata, 0);
      drive(1, 0, (i == 0), 7);
    end
    check("lit_overflow_err", overflow_err_o, 1);
    check("lit_overflow_no_range", range_err_o, 0);
    check("lit_overflow_count", free_count_o, 16);
    for (int i = 0; i < 16; i++) begin
      check("lit_post_ovf_seq", m_done_tdata, i);
      drive(1, 1, 0, 0);
    end

    // Reset for one cycle in the middle of a drain.
    drive(0, 1, 0, 0);
    repeat (18) drive(1, 1, 0, 0);
    repeat (5) drive(1, 1, 0, 0);
    drive(0, 1, 0, 0);
    check("lit_rst_tvalid", m_done_tvalid, 0);
    check("lit_rst_tdata", m_done_tdata, 0);
    check("lit_rst_count", free_count_o, 0);
    check("lit_rst_init_done", init_done_o, 0);
    check("lit_rst_tready", s_free_tready, 0);
    check("lit_rst_ovf", overflow_err_o, 0);
    repeat (18) drive(1, 1, 0, 0);
    check("lit_restart_valid", m_done_tvalid, 1);
    check("lit_restart_data", m_done_tdata, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit rdy;
      bit fv;
      int fd;
      rdy = ($urandom_range(0, 3) != 0);
      fv  = ($urandom_range(0, 2) != 0);
      fd  = ($urandom_range(0, 15) == 0) ? 16 + int'($urandom_range(0, 15)) : int'($urandom_range(0, 15));
      drive(1, rdy, fv, fd);
    end
    repeat (4) drive(1, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pueo_event_addr_freelist
